dff_sync_rst: RTL and testbench



---
 rtl/dff_sync_rst_if.sv | 19 +
 rtl/dff_sync_rst.sv | 60 ++++++
 tb/tb_dff_sync_rst.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dff_sync_rst_if.sv
// dff_sync_rst_if: data bus of the dff_sync_rst register/pipeline.
// The master drives D and reads Q/Q_N. The register is the slave.
// Optional feature macro: DFF_SYNC_RST_CE_EN adds the active-high clock enable CE.
interface dff_sync_rst_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_N;
`ifdef DFF_SYNC_RST_CE_EN
    logic             CE;

    modport master (output D, output CE, input Q, input Q_N);
    modport slave  (input D, input CE, output Q, output Q_N);
`else
    modport master (output D, input Q, input Q_N);
    modport slave  (input D, output Q, output Q_N);
`endif
endinterface

// File: rtl/dff_sync_rst.sv
// dff_sync_rst: parameterizable D register/pipeline with a synchronous,
// active-low reset (RST == 0 loads RESET_VALUE into every stage on a CLK edge).
// STAGES cascaded registers give a D-to-Q latency of STAGES cycles (legal 1..16).
// Q is the last stage. Q_N is its bitwise complement.
// Optional feature macro: DFF_SYNC_RST_CE_EN adds CE on the bus. With CE low the
// stages hold. Reset still wins over CE.
module dff_sync_rst #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                CLK,
    input  logic                RST,
    dff_sync_rst_if.slave       bus
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];
    logic             advance;

    // Shift enable: the clock enable when the feature is built in, otherwise always on.
    always_comb begin
`ifdef DFF_SYNC_RST_CE_EN
        advance = bus.CE;
`else
        advance = 1'b1;
`endif
    end

    // Next stage contents: hold by default, shift D into the chain when enabled.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (advance) begin
            stage_d[0] = bus.D;
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers. Reset is sampled only on the clock edge and discards
    // everything in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign bus.Q   = stage_q[STAGES-1];
    assign bus.Q_N = ~stage_q[STAGES-1];

endmodule

// File: tb/tb_dff_sync_rst.sv
// tb_dff_sync_rst: directed bench for dff_sync_rst.
// DUT A uses the defaults (1 bit, 1 stage).
// DUT B uses WIDTH=8, STAGES=3 and RESET_VALUE=8'hA5.
// The driver pushes the expected Q after each edge. A negedge monitor pops the
// value and compares it with both Q and Q_N.
`timescale 1ns/100ps
module tb_dff_sync_rst;

  logic clk;
  logic rst_a;
  logic rst_b;

  dff_sync_rst_if #(.WIDTH(1)) bus_a ();
  dff_sync_rst_if #(.WIDTH(8)) bus_b ();

  dff_sync_rst dut_a (
    .CLK (clk),
    .RST (rst_a),
    .bus (bus_a.slave)
  );

  dff_sync_rst #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) dut_b (
    .CLK (clk),
    .RST (rst_b),
    .bus (bus_b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  // scoreboard
  logic [0:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: each pushed expectation is compared at the negedge following its edge
  initial begin
    logic [0:0] ea;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (exp_a_q.size() > 0) begin
        ea = exp_a_q.pop_front();
        check("a_q", {7'b0, bus_a.Q}, {7'b0, ea});
        check("a_qn", {7'b0, bus_a.Q_N}, {7'b0, ~ea});
      end
      if (exp_b_q.size() > 0) begin
        eb = exp_b_q.pop_front();
        check("b_q", bus_b.Q, eb);
        check("b_qn", bus_b.Q_N, ~eb);
      end
    end
  end

  // driver tasks
  // glitch=1 flips RST briefly between edges and then restores it.
  task automatic step_a(input logic d, input logic rst, input logic glitch, input logic exp);
    bus_a.D = d;
    rst_a = rst;
    if (glitch) begin
      #0.2 rst_a = ~rst;
      #0.4 rst_a = rst;
    end
    @(posedge clk);
    exp_a_q.push_back(exp);
    #1;
  endtask

  task automatic step_b(input logic [7:0] d, input logic rst, input logic [7:0] exp);
    bus_b.D = d;
    rst_b = rst;
`ifdef DFF_SYNC_RST_CE_EN
    bus_b.CE = 1'b1;
`endif
    @(posedge clk);
    exp_b_q.push_back(exp);
    #1;
  endtask

`ifdef DFF_SYNC_RST_CE_EN
  task automatic step_b_ce(input logic [7:0] d, input logic rst, input logic ce, input logic [7:0] exp);
    bus_b.D = d;
    rst_b = rst;
    bus_b.CE = ce;
    @(posedge clk);
    exp_b_q.push_back(exp);
    #1;
  endtask
`endif

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.D = 1'b0;
    bus_b.D = 8'h00;
`ifdef DFF_SYNC_RST_CE_EN
    bus_a.CE = 1'b1;
    bus_b.CE = 1'b1;
`endif

    // DUT A: power-up reset, with Q and Q_N defined after the first edge
    step_a(1'b0, 1'b0, 1'b0, 1'b0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0);
    // D=1 while reset is held keeps Q at 0
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    // RST goes briefly high between edges but is low at the edge: still reset
    step_a(1'b1, 1'b0, 1'b1, 1'b0);
    // release, then D=1 for exactly one cycle
    step_a(1'b0, 1'b1, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0, 1'b1);
    step_a(1'b0, 1'b1, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 1'b0, 1'b0);
    // RST pulses low between edges: Q is unchanged and the next edge captures D
    step_a(1'b1, 1'b1, 1'b1, 1'b1);
    step_a(1'b0, 1'b1, 1'b0, 1'b0);

    // DUT B: reset, then fill the 3-stage pipe
    step_b(8'hFF, 1'b0, 8'hA5);
    step_b(8'hFF, 1'b0, 8'hA5);
    step_b(8'h01, 1'b1, 8'hA5);
    step_b(8'h02, 1'b1, 8'hA5);
    step_b(8'h03, 1'b1, 8'h01);
    step_b(8'h04, 1'b1, 8'h02);
    step_b(8'h05, 1'b1, 8'h03);
    step_b(8'h06, 1'b1, 8'h04);
    // reset for one edge in mid-stream flushes the pipe
    step_b(8'h07, 1'b0, 8'hA5);
    step_b(8'h08, 1'b1, 8'hA5);
    step_b(8'h09, 1'b1, 8'hA5);
    step_b(8'h0A, 1'b1, 8'h08);
    step_b(8'h0B, 1'b1, 8'h09);
    step_b(8'h0C, 1'b1, 8'h0A);

`ifdef DFF_SYNC_RST_CE_EN
    // CE low holds the pipe, but reset overrides CE
    step_b_ce(8'h55, 1'b1, 1'b0, 8'h0A);
    step_b_ce(8'hAA, 1'b1, 1'b0, 8'h0A);
    step_b_ce(8'h55, 1'b0, 1'b0, 8'hA5);
    step_b_ce(8'h11, 1'b1, 1'b1, 8'hA5);
    step_b_ce(8'hAA, 1'b1, 1'b0, 8'hA5);
    step_b_ce(8'h22, 1'b1, 1'b1, 8'hA5);
    step_b_ce(8'h33, 1'b1, 1'b1, 8'h11);
`endif

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && (exp_a_q.size() > 0 || exp_b_q.size() > 0); i++) begin
      @(posedge clk);
    end
    checks++;
    if (exp_a_q.size() > 0 || exp_b_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", exp_a_q.size(), exp_b_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
